mem_ctrl_seq: RTL and testbench

//  Sequential byte-serial memory controller between IF/MEM stages and the 8-bit single-port RAM.

---
 rtl/mem_ctrl_seq.sv | 250 +++++++++++++++++++++++++
 tb/tb_mem_ctrl_seq.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_seq.sv
// mem_ctrl_seq: byte-serial memory controller between the IF/MEM pipeline stages and an
// 8-bit single-port RAM with one cycle of read latency. One transaction owns the RAM at a
// time; MEM has priority over IF. Multi-byte accesses are little-endian and are split or
// assembled one byte per cycle. Each port gets a registered one-cycle done pulse.
//
// Optional build macro: MEM_CTRL_IF_ABORT_EN
//   When defined, a data request arriving during a fetch aborts the fetch and is accepted
//   at once; the still-held fetch request restarts from byte 0 once the data access ends.
//   When undefined, a fetch always runs to completion and data requests wait for IDLE.
module mem_ctrl_seq #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned IF_BYTES   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  // Instruction-fetch port
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic [8*IF_BYTES-1:0]   if_data,
  output logic                    if_done,
  // Data port
  input  logic                    mem_req,
  input  logic                    mem_we,
  input  logic [1:0]              mem_size,
  input  logic                    mem_signed,
  input  logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [31:0]             mem_wdata,
  output logic [31:0]             mem_rdata,
  output logic                    mem_done,
  // RAM side
  input  logic [7:0]              ram_din,
  output logic [7:0]              ram_dout,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic                    ram_wr
);

  typedef enum logic [1:0] {
    StIdle,
    StIfRd,
    StMemRd,
    StMemWr
  } state_e;

  localparam logic [2:0] IfN = 3'(IF_BYTES);

  // Byte count for a data access; the 11 encoding behaves as a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    logic [2:0] n;
    unique case (size)
      2'b00:   n = 3'd1;
      2'b01:   n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // Fill the bits above the loaded bytes with zero or the top loaded bit.
  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] n,
                                         input logic sgn);
    logic [31:0] res;
    unique case (n)
      3'd1:    res = {{24{sgn & raw[7]}}, raw[7:0]};
      3'd2:    res = {{16{sgn & raw[15]}}, raw[15:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

  state_e                  state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [2:0]              n_q, n_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    signed_q, signed_d;
  logic [31:0]             rbuf_q, rbuf_d;
  logic [8*IF_BYTES-1:0]   if_data_q, if_data_d;
  logic                    if_done_q, if_done_d;
  logic [31:0]             mem_rdata_q, mem_rdata_d;
  logic                    mem_done_q, mem_done_d;

  logic                    start_mem;
  logic                    start_if;
  logic                    if_abort;
  logic                    rd_phase;
  logic [7:0]              wbyte;
  logic [ADDR_WIDTH-1:0]   cur_addr;

`ifdef MEM_CTRL_IF_ABORT_EN
  assign if_abort = mem_req;
`else
  assign if_abort = 1'b0;
`endif

  assign rd_phase = (state_q == StIfRd) || (state_q == StMemRd);
  assign cur_addr = base_q + ADDR_WIDTH'(cnt_q);

  // Capture the byte addressed in the previous cycle into its little-endian slot.
  always_comb begin
    rbuf_d = rbuf_q;
    if (rd_phase) begin
      for (int i = 0; i < 4; i++) begin
        if (cnt_q == 3'(i + 1)) begin
          rbuf_d[8*i +: 8] = ram_din;
        end
      end
    end
  end

  // Select the store byte for the current count.
  always_comb begin
    wbyte = wdata_q[7:0];
    unique case (cnt_q[1:0])
      2'd0: wbyte = wdata_q[7:0];
      2'd1: wbyte = wdata_q[15:8];
      2'd2: wbyte = wdata_q[23:16];
      2'd3: wbyte = wdata_q[31:24];
      default: wbyte = wdata_q[7:0];
    endcase
  end

  // Next-state logic: arbitration, byte sequencing and result hand-off.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    signed_d    = signed_q;
    if_data_d   = if_data_q;
    if_done_d   = 1'b0;
    mem_rdata_d = mem_rdata_q;
    mem_done_d  = 1'b0;
    start_mem   = 1'b0;
    start_if    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A done cycle never accepts, so a request still held for it is not re-served.
        if (!if_done_q && !mem_done_q) begin
          if (mem_req) begin
            start_mem = 1'b1;
          end else if (if_req) begin
            start_if = 1'b1;
          end
        end
      end
      StIfRd: begin
        if (if_abort) begin
          start_mem = 1'b1;
        end else if (cnt_q == n_q) begin
          if_done_d = 1'b1;
          if_data_d = rbuf_d[8*IF_BYTES-1:0];
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StMemRd: begin
        if (cnt_q == n_q) begin
          mem_done_d  = 1'b1;
          mem_rdata_d = extend(rbuf_d, n_q, signed_q);
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StMemWr: begin
        if (cnt_q == n_q - 3'd1) begin
          mem_done_d = 1'b1;
          state_d    = StIdle;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Latch the request so later input changes cannot disturb the transaction.
    if (start_mem) begin
      state_d  = mem_we ? StMemWr : StMemRd;
      cnt_d    = 3'd0;
      base_d   = mem_addr;
      n_d      = size_bytes(mem_size);
      wdata_d  = mem_wdata;
      signed_d = mem_signed;
    end else if (start_if) begin
      state_d = StIfRd;
      cnt_d   = 3'd0;
      base_d  = if_addr;
      n_d     = IfN;
    end
  end

  // Drive the RAM: address the next byte while one remains, zero otherwise.
  always_comb begin
    ram_addr = '0;
    ram_dout = '0;
    ram_wr   = 1'b0;
    unique case (state_q)
      StIfRd, StMemRd: begin
        if (cnt_q < n_q) begin
          ram_addr = cur_addr;
        end
      end
      StMemWr: begin
        ram_addr = cur_addr;
        ram_dout = wbyte;
        ram_wr   = 1'b1;
      end
      default: begin
        ram_addr = '0;
      end
    endcase
  end

  // State and result registers; reset drops any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      n_q         <= '0;
      base_q      <= '0;
      wdata_q     <= '0;
      signed_q    <= 1'b0;
      rbuf_q      <= '0;
      if_data_q   <= '0;
      if_done_q   <= 1'b0;
      mem_rdata_q <= '0;
      mem_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      signed_q    <= signed_d;
      rbuf_q      <= rbuf_d;
      if_data_q   <= if_data_d;
      if_done_q   <= if_done_d;
      mem_rdata_q <= mem_rdata_d;
      mem_done_q  <= mem_done_d;
    end
  end

  assign if_data   = if_data_q;
  assign if_done   = if_done_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_done  = mem_done_q;

endmodule

// File: tb/tb_mem_ctrl_seq.sv
// Bench for mem_ctrl_seq: directed scenarios plus random loads, stores and fetches, checked
// against a byte-array memory model and cycle-exact latency expectations.
module tb_mem_ctrl_seq;
  localparam int unsigned AW  = 32;
  localparam int unsigned IFB = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [AW-1:0]     if_addr;
  logic [8*IFB-1:0]  if_data;
  logic              if_done;
  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_size;
  logic              mem_signed;
  logic [AW-1:0]     mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_done;
  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;
  logic [AW-1:0]     ram_addr;
  logic              ram_wr;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Physical RAM (driven by the DUT) and the expected contents; both fold addresses the same way.
  logic [7:0] ram [1024];
  logic [7:0] ref_mem [1024];
  logic       ld_en;
  logic [9:0] ld_idx;
  logic [7:0] ld_val;

  logic [31:0]      last_rd;
  logic [8*IFB-1:0] last_if;

  always #5 clk = ~clk;

  mem_ctrl_seq #(
    .ADDR_WIDTH (AW),
    .IF_BYTES   (IFB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_data    (if_data),
    .if_done    (if_done),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_size   (mem_size),
    .mem_signed (mem_signed),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_done   (mem_done),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout),
    .ram_addr   (ram_addr),
    .ram_wr     (ram_wr)
  );

  function automatic logic [9:0] idx(input logic [31:0] a);
    return {a[31], a[8:0]};
  endfunction

  // Single-port RAM, read latency 1.
  always @(posedge clk) begin
    if (ld_en) begin
      ram[ld_idx] <= ld_val;
    end else if (ram_wr) begin
      ram[idx(ram_addr)] <= ram_dout;
    end
    ram_din <= ram[idx(ram_addr)];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] v);
    ref_mem[idx(a)] = v;
    ld_en  = 1'b1;
    ld_idx = idx(a);
    ld_val = v;
    tick();
    ld_en = 1'b0;
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] load_model(input logic [31:0] a, input int n, input logic sgn);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) begin
      v = v | (32'(ref_mem[idx(a + 32'(i))]) << (8 * i));
    end
    if (n < 4 && sgn && v[8*n-1]) begin
      v = v | (32'hFFFF_FFFF << (8 * n));
    end
    return v;
  endfunction

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 1) == 0) return 32'($urandom_range(0, 511));
    return 32'hFFFF_FE00 + 32'($urandom_range(0, 511));
  endfunction

  // One data access, starting in a cycle where the controller can accept it.
  task automatic mem_txn(input logic we, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] a, input logic [31:0] wd);
    int          n    = nbytes(sz);
    int          last = we ? n + 1 : n + 2;
    logic [31:0] exp  = load_model(a, n, sgn);
    logic [31:0] ea;
    mem_req = 1'b1; mem_we = we; mem_size = sz; mem_signed = sgn;
    mem_addr = a; mem_wdata = wd;
    for (int j = 1; j <= last; j++) begin
      tick();
      if (j == 1) begin
        // Latched copies must be used from here on.
        mem_addr = $urandom; mem_wdata = $urandom; mem_size = 2'($urandom);
        mem_signed = 1'($urandom); mem_we = ~we;
      end
      ea = a + 32'(j - 1);
      check($sformatf("mem_done j%0d", j), 64'(mem_done), 64'(j == last));
      check($sformatf("if_done in mem j%0d", j), 64'(if_done), 64'(0));
      if (j <= n) begin
        check($sformatf("ram_addr j%0d", j), 64'(ram_addr), 64'(ea));
        check($sformatf("ram_wr j%0d", j), 64'(ram_wr), 64'(we));
        if (we) check($sformatf("ram_dout j%0d", j), 64'(ram_dout), 64'(8'(wd >> (8 * (j - 1)))));
      end else if (j == last) begin
        check("ram_addr done", 64'(ram_addr), 64'(0));
        check("ram_wr done", 64'(ram_wr), 64'(0));
      end
    end
    if (we) begin
      for (int i = 0; i < n; i++) ref_mem[idx(a + 32'(i))] = 8'(wd >> (8 * i));
    end else begin
      check("mem_rdata", 64'(mem_rdata), 64'(exp));
      last_rd = exp;
    end
    mem_req = 1'b0;
    tick();
    check("mem_done pulse", 64'(mem_done), 64'(0));
    if (!we) check("mem_rdata hold", 64'(mem_rdata), 64'(last_rd));
    check("if_data hold", 64'(if_data), 64'(last_if));
  endtask

  // One fetch, starting in a cycle where the controller can accept it.
  task automatic if_txn(input logic [31:0] a);
    logic [31:0] exp = load_model(a, IFB, 1'b0);
    if_req = 1'b1; if_addr = a;
    for (int j = 1; j <= IFB + 2; j++) begin
      tick();
      if (j == 1) if_addr = $urandom;
      check($sformatf("if_done j%0d", j), 64'(if_done), 64'(j == IFB + 2));
      check($sformatf("mem_done in if j%0d", j), 64'(mem_done), 64'(0));
      if (j <= IFB) begin
        check($sformatf("if ram_addr j%0d", j), 64'(ram_addr), 64'(a + 32'(j - 1)));
        check($sformatf("if ram_wr j%0d", j), 64'(ram_wr), 64'(0));
      end
    end
    check("if_data", 64'(if_data), 64'(exp));
    last_if = exp[8*IFB-1:0];
    if_req = 1'b0;
    tick();
    check("if_done pulse", 64'(if_done), 64'(0));
    check("if_data hold", 64'(if_data), 64'(last_if));
  endtask

  initial begin
    int          cyc;
    logic [31:0] exp_if;
    rst = 1'b1; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
    mem_size = '0; mem_signed = 1'b0; mem_addr = '0; mem_wdata = '0;
    ld_en = 1'b0; ld_idx = '0; ld_val = '0;
    last_rd = '0; last_if = '0;

    // Fill RAM while reset is held.
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i] = 8'($urandom);
      ld_en = 1'b1; ld_idx = 10'(i); ld_val = ref_mem[i];
      tick();
    end
    ld_en = 1'b0;
    tick();
    check("rst if_data", 64'(if_data), 64'(0));
    check("rst if_done", 64'(if_done), 64'(0));
    check("rst mem_rdata", 64'(mem_rdata), 64'(0));
    check("rst mem_done", 64'(mem_done), 64'(0));
    check("rst ram_addr", 64'(ram_addr), 64'(0));
    check("rst ram_dout", 64'(ram_dout), 64'(0));
    check("rst ram_wr", 64'(ram_wr), 64'(0));
    rst = 1'b0;
    tick();

    // Directed fetch of a known instruction word.
    poke(32'h100, 8'h13); poke(32'h101, 8'h00); poke(32'h102, 8'h00); poke(32'h103, 8'h00);
    if_txn(32'h100);
    check("fetch 0x100", 64'(if_data), 64'(32'h0000_0013));

    // Sign/zero extension.
    poke(32'h20, 8'h80); poke(32'h21, 8'h7F);
    mem_txn(1'b0, 2'b00, 1'b1, 32'h20, 32'h0);
    check("lb 0x20", 64'(mem_rdata), 64'(32'hFFFF_FF80));
    mem_txn(1'b0, 2'b00, 1'b0, 32'h20, 32'h0);
    check("lbu 0x20", 64'(mem_rdata), 64'(32'h0000_0080));
    mem_txn(1'b0, 2'b01, 1'b1, 32'h20, 32'h0);
    check("lh 0x20", 64'(mem_rdata), 64'(32'h0000_7F80));

    // Store word, then read it back.
    mem_txn(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEAD_BEEF);
    check("ram_wr after sw", 64'(ram_wr), 64'(0));
    mem_txn(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    check("lw 0x40", 64'(mem_rdata), 64'(32'hDEAD_BEEF));

    // Address wrap at the top of memory.
    mem_txn(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h0);

    // Reset during a word read: dropped, no done.
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b10; mem_addr = 32'h30;
    tick(); tick();
    rst = 1'b1; mem_req = 1'b0;
    tick();
    check("rst rd ram_wr", 64'(ram_wr), 64'(0));
    check("rst rd ram_addr", 64'(ram_addr), 64'(0));
    check("rst rd mem_done", 64'(mem_done), 64'(0));
    check("rst rd mem_rdata", 64'(mem_rdata), 64'(0));
    check("rst rd if_data", 64'(if_data), 64'(0));
    last_rd = '0; last_if = '0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("post rst mem_done", 64'(mem_done), 64'(0));
      check("post rst if_done", 64'(if_done), 64'(0));
    end

    // Reset during a word store: the two bytes already written stay, the rest never happen.
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'b10; mem_addr = 32'h50; mem_wdata = 32'hA1B2_C3D4;
    tick();
    check("st rst ram_wr", 64'(ram_wr), 64'(1));
    tick();
    rst = 1'b1; mem_req = 1'b0;
    tick();
    check("rst wr ram_wr", 64'(ram_wr), 64'(0));
    check("rst wr ram_addr", 64'(ram_addr), 64'(0));
    ref_mem[idx(32'h50)] = 8'hD4;
    ref_mem[idx(32'h51)] = 8'hC3;
    tick();
    rst = 1'b0;
    tick();
    mem_txn(1'b0, 2'b10, 1'b0, 32'h50, 32'h0);

    // Simultaneous requests: MEM first, then the held fetch.
    if_req = 1'b1; if_addr = 32'h104;
    mem_txn(1'b0, 2'b10, 1'b0, 32'h44, 32'h0);
    if_txn(32'h104);

`ifdef MEM_CTRL_IF_ABORT_EN
    // Data request mid-fetch aborts it; fetch restarts afterwards.
    if_req = 1'b1; if_addr = 32'h180;
    tick(); tick();
    mem_txn(1'b0, 2'b10, 1'b0, 32'h60, 32'h0);
    if_txn(32'h180);
`else
    // Data request mid-fetch waits for the fetch to finish.
    if_req = 1'b1; if_addr = 32'h180;
    exp_if = load_model(32'h180, IFB, 1'b0);
    tick(); tick();
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b10; mem_signed = 1'b0; mem_addr = 32'h60;
    cyc = 2;
    while (!if_done && cyc < 20) begin
      check("mem_done during fetch", 64'(mem_done), 64'(0));
      tick();
      cyc++;
    end
    check("fetch latency", 64'(cyc), 64'(IFB + 2));
    check("fetch data", 64'(if_data), 64'(exp_if));
    last_if = exp_if[8*IFB-1:0];
    if_req = 1'b0;
    tick();
    mem_txn(1'b0, 2'b10, 1'b0, 32'h60, 32'h0);
`endif

    // Random mix.
    for (int k = 0; k < 60; k++) begin
      int sel = $urandom_range(0, 3);
      if (sel == 0) begin
        if_txn(rand_addr());
      end else if (sel == 1) begin
        mem_txn(1'b1, 2'($urandom), 1'b0, rand_addr(), $urandom);
      end else begin
        mem_txn(1'b0, 2'($urandom), 1'($urandom), rand_addr(), 32'h0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
